// File: rtl/rr_voq_picker_if.sv
// rr_voq_picker_if: bundle between the round-robin VOQ picker and the
// dequeue/crossbar scheduler.
//   voq_empty  : bit i=1 means VOQ i holds nothing
//   voq_mask   : bit i=1 means VOQ i may be picked
//   pick_valid : pick_idx carries a grant
//   pick_idx   : granted VOQ index
//   pick_ready : consumer takes the grant (valid & ready)
//   all_empty  : no VOQ is both non-empty and eligible
//   rr_ptr     : current highest-priority VOQ (status)
// master = picker side, slave = scheduler side.
interface rr_voq_picker_if #(
  parameter int NUM_VOQ = 4,
  parameter int IDX_W   = $clog2(NUM_VOQ)
);
  logic [NUM_VOQ-1:0] voq_empty;
  logic [NUM_VOQ-1:0] voq_mask;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_ready;
  logic               all_empty;
  logic [IDX_W-1:0]   rr_ptr;

  modport master (
    input  voq_empty, voq_mask, pick_ready,
    output pick_valid, pick_idx, all_empty, rr_ptr
  );

  modport slave (
    output voq_empty, voq_mask, pick_ready,
    input  pick_valid, pick_idx, all_empty, rr_ptr
  );
endinterface

// File: rtl/rr_voq_picker.sv
// rr_voq_picker: registered round-robin selector over NUM_VOQ virtual output
// queues. Searches for the first requesting VOQ starting at rr_ptr, presents
// it as a held grant until the consumer accepts, then inserts one bubble so
// voq_empty can reflect the dequeue. A VOQ may keep priority for up to
// MAX_BURST consecutive picks before the pointer rotates past it.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (master) : voq_empty/voq_mask/pick_ready in,
//                  pick_valid/pick_idx/all_empty/rr_ptr out
module rr_voq_picker #(
  parameter int NUM_VOQ   = 4,
  parameter int IDX_W     = $clog2(NUM_VOQ),
  parameter int MAX_BURST = 1,
  parameter int BURST_W   = $clog2(MAX_BURST+1)
) (
  input  logic               clk,
  input  logic               reset_n,
  rr_voq_picker_if.master    bus
);

  localparam logic [IDX_W:0]     NV_EXT     = (IDX_W+1)'(NUM_VOQ);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_VOQ-1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST-1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t             r_state;
  logic               r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic [BURST_W-1:0] r_burst;

  logic [NUM_VOQ-1:0] w_req;
  logic               w_any;
  logic [IDX_W-1:0]   w_sel;

  // Modular add for a non-power-of-2 ring: one extra bit, then subtract
  // NUM_VOQ once, since base and offset are both below NUM_VOQ.
  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                              input logic [IDX_W-1:0] off);
    logic [IDX_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= NV_EXT) s = s - NV_EXT;
    return s[IDX_W-1:0];
  endfunction

  assign w_req = ~bus.voq_empty & bus.voq_mask;
  assign w_any = |w_req;

  // Walk offsets from farthest to nearest so the nearest requester from
  // r_ptr is the last (winning) assignment.
  always_comb begin
    w_sel = '0;
    for (int k = NUM_VOQ-1; k >= 0; k--) begin
      if (w_req[f_wrap(r_ptr, IDX_W'(k))]) w_sel = f_wrap(r_ptr, IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_sel;
            r_valid <= 1'b1;
            r_state <= S_GRANT;
            // A different VOQ won: its burst starts from zero.
            if (w_sel != r_ptr) r_burst <= '0;
          end
        end
        S_GRANT: begin
          // Grant is held regardless of input changes until accepted.
          if (bus.pick_ready) begin
            r_valid <= 1'b0;
            r_state <= S_GAP;
            // r_burst never exceeds BURST_LAST, so != is the "more picks
            // left in this burst" test.
            if (r_burst != BURST_LAST) begin
              r_burst <= r_burst + 1'b1;
              r_ptr   <= r_idx;
            end else begin
              r_burst <= '0;
              r_ptr   <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pick_valid = r_valid;
  assign bus.pick_idx   = r_idx;
  assign bus.rr_ptr     = r_ptr;
  assign bus.all_empty  = ~w_any;

endmodule
